// File: rtl/decoder2x4_pipe_pkg.sv
// Shared defaults and occupancy encoding for the pipelined 2-to-4 decoder.
package decoder2x4_pipe_pkg;

    localparam int unsigned CODE_W_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/decoder2x4_pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decoder2x4_pipe.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer and
// per-line saturating hit counters.
module decoder2x4_pipe
    import decoder2x4_pipe_pkg::*;
#(
    parameter  int unsigned CODE_W = CODE_W_DEF,
    parameter  int unsigned CNT_W  = CNT_W_DEF,
    localparam int unsigned LINES  = 2**CODE_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      in_code,
    input  logic                   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LINES-1:0]       out_onehot,
    input  logic                   cnt_clr,
    output logic [LINES*CNT_W-1:0] hit_cnt
);

    occ_e             state_q;
    occ_e             state_d;
    logic [LINES-1:0] out_reg;
    logic [LINES-1:0] skid_reg;
    logic [LINES-1:0] pattern;
    logic             skid_valid;
    logic             accept;
    logic             emit;

    function automatic logic [LINES-1:0] decode(input logic [CODE_W-1:0] code,
                                                input logic              en);
        logic [LINES-1:0] p;
        p = '0;
        if (en) p[code] = 1'b1;
        return p;
    endfunction

    assign pattern = decode(in_code, in_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !emit)      state_d = FULL;
                else if (!accept && emit) state_d = EMPTY;
            end
            FULL:    if (emit) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Handshake flags decode only the state register, so in_ready never
    // depends combinationally on out_ready.
    always_comb begin
        out_valid  = (state_q != EMPTY);
        skid_valid = (state_q == FULL);
        in_ready   = !skid_valid;
        accept     = in_valid && !skid_valid;
        emit       = out_valid && out_ready;
        out_onehot = out_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) out_reg <= pattern;
                ONE: begin
                    if (accept && emit)  out_reg  <= pattern;
                    else if (accept)     skid_reg <= pattern;
                end
                FULL:    if (emit) out_reg <= skid_reg;
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < LINES; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (emit && out_reg[i]),
            .clr   (cnt_clr),
            .cnt   (hit_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule
